// File: rtl/matvec_pkg.sv
// matvec_pkg: shared widths and element types for the matvec datapath stages.
package matvec_pkg;
   localparam int IN_ELEM_W  = 28;
   localparam int OUT_ELEM_W = 14;
   localparam int VEC_LEN_D  = 8;
   typedef logic signed [IN_ELEM_W-1:0]  in_elem_t;
   typedef logic signed [OUT_ELEM_W-1:0] out_elem_t;
   typedef struct packed {
      out_elem_t data;
      logic      last;
   } rq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count and full/empty flags.
module sync_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt;
   logic             push_ok, pop_ok;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rp];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop_ok) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end
   always_ff @(posedge clk)
      if (push_ok) mem[wp] <= wdata;
endmodule

// File: rtl/matvec_requant_out.sv
// matvec_requant_out: rounds, shifts, optionally ReLUs and saturates the dot-product
// stream, then queues the result with a per-vector last tag for the next layer.
module matvec_requant_out
   import matvec_pkg::*;
#(
   parameter int IN_W    = IN_ELEM_W,
   parameter int OUT_W   = OUT_ELEM_W,
   parameter int SHIFT   = 4,
   parameter int RELU    = 1,
   parameter int VEC_LEN = VEC_LEN_D,
   parameter int DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    input_valid,
   output logic                    input_ready,
   input  logic signed [IN_W-1:0]  input_data,
   output logic                    output_valid,
   input  logic                    output_ready,
   output logic signed [OUT_W-1:0] output_data,
   output logic                    output_last
);
   localparam int IW = $clog2(VEC_LEN);
   localparam logic signed [IN_W:0] HALF = ((IN_W+1)'(1) << SHIFT) >> 1;
   localparam logic signed [IN_W:0] RMAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] RMIN = ~RMAX;
   logic signed [IN_W:0]    ext, rnd, sh, rl;
   logic signed [OUT_W-1:0] sat;
   logic [IW-1:0]           idx;
   logic [OUT_W:0]          head;
   logic                    full, empty, push;
   // One extra bit of headroom keeps the rounding add from overflowing.
   always_comb begin
      ext = {input_data[IN_W-1], input_data};
      rnd = ext + HALF;
      sh  = rnd >>> SHIFT;
      rl  = (RELU != 0 && sh < 0) ? '0 : sh;
      sat = OUT_W'(rl > RMAX ? RMAX : rl < RMIN ? RMIN : rl);
   end
   assign input_ready  = !full && !reset;
   assign push         = input_valid && input_ready;
   assign output_valid = !empty;
   assign output_data  = empty ? '0 : head[OUT_W:1];
   assign output_last  = !empty && head[0];
   always_ff @(posedge clk) begin
      if (reset) idx <= '0;
      else if (push) idx <= (idx == IW'(VEC_LEN-1)) ? '0 : idx + 1'b1;
   end
   sync_fifo #(.WIDTH(OUT_W+1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (output_ready),
      .wdata ({sat, idx == IW'(VEC_LEN-1)}),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_matvec_requant_out.sv
// tb_matvec_requant_out: drives a RELU=1 and a RELU=0 instance in lockstep and checks
// both against a queue model every cycle, plus hand-computed result lists.
module tb_matvec_requant_out;
   logic clk = 0, reset, input_valid, output_ready;
   logic signed [27:0] input_data;
   logic ir1, ov1, ol1, ir0, ov0, ol0;
   logic signed [13:0] od1, od0;
   int tests = 0, fails = 0;
   int qd1[$], qd0[$], ql[$], got1[$], got0[$], gotl[$], e1[$], e0[$];
   int idx = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   matvec_requant_out dut (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir1),
      .input_data(input_data), .output_valid(ov1), .output_ready(output_ready),
      .output_data(od1), .output_last(ol1));
   matvec_requant_out #(.RELU(0)) dut0 (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir0),
      .input_data(input_data), .output_valid(ov0), .output_ready(output_ready),
      .output_data(od0), .output_last(ol0));

   task automatic chk(string nm, longint a, longint e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   // Round half up, floor-divide by 16, optional ReLU, clamp to 14-bit signed.
   function automatic int rq(longint x, bit relu);
      longint r, q;
      r = x + 8;
      q = r / 16;
      if (r % 16 < 0) q--;
      if (relu && q < 0) q = 0;
      if (q > 8191) q = 8191;
      if (q < -8192) q = -8192;
      return int'(q);
   endfunction

   always @(negedge clk) begin
      bit do_pop, do_push;
      if (chk_on) begin
         chk("ovalid", ov1, qd1.size() > 0);
         chk("ovalid0", ov0, qd0.size() > 0);
         chk("iready", ir1, !reset && qd1.size() < 4);
         chk("iready0", ir0, !reset && qd0.size() < 4);
         chk("olast", ol1, qd1.size() > 0 ? ql[0] : 0);
         if (qd1.size() > 0) begin
            chk("odata", od1, qd1[0]);
            chk("odata0", od0, qd0[0]);
            chk("olast0", ol0, ql[0]);
         end
      end
      if (ov1 && output_ready && !reset) begin
         got1.push_back(int'(od1));
         got0.push_back(int'(od0));
         gotl.push_back(int'(ol1));
      end
      if (reset) begin
         qd1.delete(); qd0.delete(); ql.delete();
         idx = 0;
         chk_on = 1;
      end else begin
         do_pop  = qd1.size() > 0 && output_ready;
         do_push = input_valid && qd1.size() < 4;
         if (do_pop) begin
            void'(qd1.pop_front()); void'(qd0.pop_front()); void'(ql.pop_front());
         end
         if (do_push) begin
            qd1.push_back(rq(longint'(input_data), 1));
            qd0.push_back(rq(longint'(input_data), 0));
            ql.push_back(idx == 7);
            idx = (idx + 1) % 8;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int x, output int n);
      bit r;
      input_valid = 1;
      input_data = 28'(x);
      n = 0;
      do begin
         @(negedge clk);
         r = ir1;
         step();
         n++;
      end while (!r && n < 100);
      input_valid = 0;
      if (!r) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      output_ready = 1;
      while (qd1.size() > 0 && n < 100) begin
         step();
         n++;
      end
      step();
      chk("drain", qd1.size(), 0);
   endtask

   task automatic clear_got();
      got1.delete(); got0.delete(); gotl.delete(); e1.delete(); e0.delete();
   endtask

   task automatic check_got(string nm);
      chk({nm, "_n"}, got1.size(), e1.size());
      for (int i = 0; i < e1.size() && i < got1.size(); i++) chk(nm, got1[i], e1[i]);
      if (e0.size() > 0) begin
         chk({nm, "_n0"}, got0.size(), e0.size());
         for (int i = 0; i < e0.size() && i < got0.size(); i++) chk({nm, "_r0"}, got0[i], e0[i]);
      end
   endtask

   task automatic do_reset();
      input_valid = 0;
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, acc, sent, cyc;
      int t1[8] = '{16100, 5180, 1808, 6789, 5998, 3793, 3412, 7983};
      int v4[6] = '{16, 32, 48, 64, 80, 96};
      reset = 1; input_valid = 0; input_data = 0; output_ready = 1;
      step(); step();
      reset = 0;
      @(negedge clk);
      chk("rst_ready", ir1, 1);
      chk("rst_valid", ov1, 0);
      chk("rst_last", ol1, 0);
      step();
      // Streaming vector with continuous ready: one element per cycle.
      clear_got();
      e1 = '{1006, 324, 113, 424, 375, 237, 213, 499};
      foreach (t1[i]) begin
         send(t1[i], n);
         chk("tput", n, 1);
      end
      drain();
      check_got("vec");
      for (int i = 0; i < 8 && i < gotl.size(); i++) chk("vec_last", gotl[i], i == 7);
      // Rounding and ReLU on both instances.
      clear_got();
      e1 = '{2, 1, 0, 0};
      e0 = '{2, 1, -863, -1};
      send(24, n); send(23, n); send(-13810, n); send(-24, n);
      drain();
      check_got("round");
      // Saturation, including the extreme inputs.
      clear_got();
      e1 = '{8191, 0, 8191, 0};
      e0 = '{8191, -8192, 8191, -8192};
      send(200000, n); send(-200000, n); send(134217727, n); send(-134217728, n);
      drain();
      check_got("sat");
      // Backpressure: only DEPTH elements fit while output_ready is low.
      clear_got();
      e1 = '{1, 2, 3, 4, 5, 6};
      output_ready = 0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         input_valid = 1;
         input_data = 28'(v4[acc]);
         @(negedge clk);
         if (ir1) acc++;
         step();
      end
      input_valid = 0;
      chk("bp_accepted", acc, 4);
      @(negedge clk);
      chk("bp_ready", ir1, 0);
      step();
      output_ready = 1;
      for (int i = acc; i < 6; i++) send(v4[i], n);
      drain();
      check_got("bp");
      // Simultaneous push and pop with two entries held.
      clear_got();
      e1 = '{1, 2, 3, 4, 5, 6};
      output_ready = 0;
      send(16, n); send(32, n);
      output_ready = 1;
      for (int k = 0; k < 4; k++) begin
         input_valid = 1;
         input_data = 28'(48 + 16 * k);
         @(negedge clk);
         chk("pushpop_cnt", dut.u_fifo.cnt, 2);
         step();
      end
      input_valid = 0;
      drain();
      check_got("pushpop");
      // Random valid/ready traffic.
      sent = 0; cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         input_valid = $urandom_range(0, 1) == 1;
         input_data = ($urandom_range(0, 3) == 0) ? 28'($urandom)
                                                  : 28'(int'($urandom_range(0, 40000)) - 20000);
         output_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (input_valid && ir1) sent++;
         step();
         cyc++;
      end
      input_valid = 0;
      chk("rand_sent", sent, 1000);
      drain();
      // Reset mid-vector with entries queued.
      do_reset();
      output_ready = 1;
      send(16, n); send(32, n);
      drain();
      output_ready = 0;
      send(48, n); send(64, n); send(80, n);
      @(negedge clk);
      chk("mid_queued", ov1, 1);
      step();
      do_reset();
      @(negedge clk);
      chk("mid_rst_valid", ov1, 0);
      chk("mid_rst_last", ol1, 0);
      chk("mid_rst_ready", ir1, 1);
      step();
      clear_got();
      output_ready = 1;
      for (int i = 0; i < 8; i++) send(100 * i, n);
      drain();
      chk("mid_n", gotl.size(), 8);
      for (int i = 0; i < 8 && i < gotl.size(); i++) chk("mid_last", gotl[i], i == 7);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
